// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG entropy arbiter: controller state encoding,
// source-index width and the default per-source stall timeout.
package trng_pkg;

    localparam int          SRC_IDX_W        = 3;
    localparam int          MAX_SRC          = 1 << SRC_IDX_W;
    localparam logic [15:0] TRNG_SRC_TIMEOUT = 16'h0400;

    typedef enum logic [1:0] {
        CTRL_IDLE     = 2'd0,
        CTRL_SELECT   = 2'd1,
        CTRL_WAIT_SYN = 2'd2,
        CTRL_PRESENT  = 2'd3
    } ctrl_state_t;

    // Index reached by stepping 'offset' places past 'base' in a ring of 'modulus' sources.
    function automatic logic [SRC_IDX_W-1:0] rr_wrap(input logic [SRC_IDX_W-1:0] base,
                                                      input int offset,
                                                      input int modulus);
        return SRC_IDX_W'((int'(base) + offset) % modulus);
    endfunction

endpackage

// File: rtl/trng_rr_select.sv
// Combinational round-robin picker: first eligible source strictly after rr_ptr,
// wrapping modulo NUM_SRC. rr_ptr itself is considered last.
module trng_rr_select import trng_pkg::*; #(
    parameter int NUM_SRC = 3
) (
    input  logic [NUM_SRC-1:0]   eligible,
    input  logic [SRC_IDX_W-1:0] rr_ptr,
    output logic [SRC_IDX_W-1:0] pick_idx,
    output logic                 pick_vld
);

    logic [MAX_SRC-1:0] elig_pad;

    assign elig_pad = MAX_SRC'(eligible);

    // Scan farthest-to-nearest so the nearest eligible source after rr_ptr wins.
    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            if (elig_pad[rr_wrap(rr_ptr, k, NUM_SRC)]) begin
                pick_idx = rr_wrap(rr_ptr, k, NUM_SRC);
                pick_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trng_entropy_arbiter.sv
// Round-robin arbiter sharing the mixer's single entropy input among NUM_SRC
// sources. One word is captured per visit; a stalled source is flagged and skipped.
module trng_entropy_arbiter import trng_pkg::*; #(
    parameter int          NUM_SRC = 3,
    parameter logic [15:0] TIMEOUT = TRNG_SRC_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_SRC-1:0]     src_enable,
    input  logic [NUM_SRC-1:0]     src_syn,
    input  logic [32*NUM_SRC-1:0]  src_data,
    output logic [NUM_SRC-1:0]     src_ack,
    output logic                   out_syn,
    output logic [31:0]            out_data,
    output logic [SRC_IDX_W-1:0]   out_src,
    input  logic                   out_ack,
    output logic [NUM_SRC-1:0]     timeout_flags,
    input  logic                   timeout_clear,
    output logic [31:0]            word_ctr
);

    localparam int DATA_PAD_W = 32 * MAX_SRC;

    ctrl_state_t            state;
    ctrl_state_t            state_nxt;
    logic [SRC_IDX_W-1:0]   rr_ptr;
    logic [SRC_IDX_W-1:0]   sel;
    logic [SRC_IDX_W-1:0]   pick_idx;
    logic                   pick_vld;
    logic [15:0]            timer;
    logic [NUM_SRC-1:0]     eligible;
    logic [MAX_SRC-1:0]     syn_pad;
    logic [MAX_SRC-1:0]     en_pad;
    logic [DATA_PAD_W-1:0]  data_pad;
    logic                   sel_syn;
    logic                   sel_en;
    logic                   do_pick;
    logic                   do_cap;
    logic                   do_drop;
    logic                   do_tmo;
    logic                   do_deliver;

    // Vectors padded to a power of two so the 3-bit sel indexes them directly.
    assign eligible = src_enable & ~timeout_flags;
    assign syn_pad  = MAX_SRC'(src_syn);
    assign en_pad   = MAX_SRC'(src_enable);
    assign data_pad = DATA_PAD_W'(src_data);
    assign sel_syn  = syn_pad[sel];
    assign sel_en   = en_pad[sel];

    trng_rr_select #(.NUM_SRC(NUM_SRC)) u_rr_select (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

    // Decode the per-cycle events; enable low suppresses every one of them.
    always_comb begin
        do_pick    = (state == CTRL_SELECT) && enable && pick_vld;
        do_cap     = (state == CTRL_WAIT_SYN) && enable && sel_syn;
        do_drop    = (state == CTRL_WAIT_SYN) && enable && !sel_syn && !sel_en;
        do_tmo     = (state == CTRL_WAIT_SYN) && enable && !sel_syn && sel_en &&
                     (timer == TIMEOUT - 16'd1);
        do_deliver = (state == CTRL_PRESENT) && enable && out_ack;
    end

    // Controller state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= CTRL_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; dropping enable returns to IDLE from anywhere.
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = CTRL_IDLE;
        end else begin
            case (state)
                CTRL_IDLE:     state_nxt = CTRL_SELECT;
                CTRL_SELECT:   if (pick_vld) state_nxt = CTRL_WAIT_SYN;
                CTRL_WAIT_SYN: begin
                    if (do_cap)                 state_nxt = CTRL_PRESENT;
                    else if (do_drop || do_tmo) state_nxt = CTRL_SELECT;
                end
                CTRL_PRESENT:  if (out_ack) state_nxt = CTRL_SELECT;
                default:       state_nxt = CTRL_IDLE;
            endcase
        end
    end

    // Word-valid to the mixer is a pure decode of PRESENT, so reset drops it at once.
    always_comb begin
        out_syn = (state == CTRL_PRESENT);
    end

    // Selection, stall timer, capture, one-cycle ack and round-robin pointer.
    // rr_ptr moves on capture so an aborted delivery resumes after that source.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr   <= SRC_IDX_W'(NUM_SRC - 1);
            sel      <= '0;
            timer    <= '0;
            out_data <= '0;
            out_src  <= '0;
            src_ack  <= '0;
        end else begin
            src_ack <= '0;
            if (do_pick) begin
                sel   <= pick_idx;
                timer <= '0;
            end else if ((state == CTRL_WAIT_SYN) && enable && !do_cap) begin
                timer <= timer + 16'd1;
            end
            if (do_cap) begin
                out_data <= data_pad[{sel, 5'd0} +: 32];
                out_src  <= sel;
                src_ack  <= NUM_SRC'(1) << sel;
            end
            if (do_cap || do_drop || do_tmo || do_deliver) rr_ptr <= sel;
        end
    end

    // Delivered-word counter; wraps silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           word_ctr <= '0;
        else if (do_deliver) word_ctr <= word_ctr + 32'd1;
    end

    // Sticky stall flags; a new timeout wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_flags <= '0;
        end else begin
            timeout_flags <= (timeout_flags & ~{NUM_SRC{timeout_clear}}) |
                             (do_tmo ? (NUM_SRC'(1) << sel) : '0);
        end
    end

endmodule

// File: tb/tb_trng_entropy_arbiter.sv
// Self-checking bench for trng_entropy_arbiter: table-driven round-robin vectors,
// hand-written multi-cycle corner cases, and a randomized run against a
// transaction-level reference model.
module tb_trng_entropy_arbiter;
    import trng_pkg::*;

    localparam int          N   = 3;
    localparam logic [15:0] TMO = 16'd16;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [N-1:0]    src_enable;
    logic [N-1:0]    src_syn;
    logic [32*N-1:0] src_data;
    logic [N-1:0]    src_ack;
    logic            out_syn;
    logic [31:0]     out_data;
    logic [2:0]      out_src;
    logic            out_ack;
    logic [N-1:0]    timeout_flags;
    logic            timeout_clear;
    logic [31:0]     word_ctr;

    int checks = 0;
    int errors = 0;

    trng_entropy_arbiter #(.NUM_SRC(N), .TIMEOUT(TMO)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .src_enable    (src_enable),
        .src_syn       (src_syn),
        .src_data      (src_data),
        .src_ack       (src_ack),
        .out_syn       (out_syn),
        .out_data      (out_data),
        .out_src       (out_src),
        .out_ack       (out_ack),
        .timeout_flags (timeout_flags),
        .timeout_clear (timeout_clear),
        .word_ctr      (word_ctr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]      mask;
        logic [5:0][2:0] seq;
    } rr_vec_t;

    rr_vec_t     tbl [6];
    logic [2:0]  ws;
    logic [31:0] wd;
    bit          ok;
    int          nw, bad_ack, ack_long, dev, found, exp_i, idle_cnt, off_cnt, m_ptr, m_src;
    logic [N-1:0] prev_ack, m_mask;
    logic [31:0] m_words, m_data;
    bit          m_pending, p_syn, p_ack, p_en;
    logic [31:0] cur [N];
    int          cd  [N];

    function automatic logic [31:0] data_of(input int i);
        case (i)
            0:       return 32'h01020304;
            1:       return 32'hdeaddead;
            default: return 32'hbeefbeef;
        endcase
    endfunction

    function automatic rr_vec_t mk(input logic [2:0] m, input int a, b, c, d, e, f);
        rr_vec_t v;
        v.mask = m;
        v.seq  = {3'(f), 3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
        return v;
    endfunction

    // Next source after ptr in mask, wrapping; -1 if none.
    function automatic int next_elig(input int ptr, input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        enable        = 1'b0;
        out_ack       = 1'b0;
        timeout_clear = 1'b0;
        src_syn       = '0;
        src_enable    = '0;
        src_data      = {data_of(2), data_of(1), data_of(0)};
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic next_word(output logic [2:0] s, output logic [31:0] d, output bit got);
        got = 1'b0;
        s   = '0;
        d   = '0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (out_syn) begin
                s   = out_src;
                d   = out_data;
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL next_word actual=no_word required=word_within_60_cycles");
        end
    endtask

    initial begin
        reset = 1'b1;
        do_reset();

        // Reset state
        chk("rst_out_syn", 32'(out_syn), 0);
        chk("rst_src_ack", 32'(src_ack), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_src", 32'(out_src), 0);
        chk("rst_flags", 32'(timeout_flags), 0);
        chk("rst_word_ctr", word_ctr, 0);

        // Table-driven round robin: all syn held high, out_ack high
        tbl[0] = mk(3'b111, 0, 1, 2, 0, 1, 2);
        tbl[1] = mk(3'b101, 0, 2, 0, 2, 0, 2);
        tbl[2] = mk(3'b110, 1, 2, 1, 2, 1, 2);
        tbl[3] = mk(3'b011, 0, 1, 0, 1, 0, 1);
        tbl[4] = mk(3'b010, 1, 1, 1, 1, 1, 1);
        tbl[5] = mk(3'b100, 2, 2, 2, 2, 2, 2);
        for (int t = 0; t < 6; t++) begin
            do_reset();
            src_enable = tbl[t].mask;
            src_syn    = 3'b111;
            out_ack    = 1'b1;
            enable     = 1'b1;
            nw = 0; bad_ack = 0; ack_long = 0; prev_ack = '0;
            for (int c = 0; c < 100 && nw < 6; c++) begin
                step();
                if ((src_ack & ~tbl[t].mask) != '0) bad_ack++;
                if (src_ack != '0 && prev_ack != '0) ack_long++;
                prev_ack = src_ack;
                if (out_syn) begin
                    chk($sformatf("rr%0d_src%0d", t, nw), 32'(out_src), 32'(tbl[t].seq[nw]));
                    chk($sformatf("rr%0d_data%0d", t, nw), out_data, data_of(int'(tbl[t].seq[nw])));
                    chk($sformatf("rr%0d_ack%0d", t, nw), 32'(src_ack), 32'(1) << tbl[t].seq[nw]);
                    nw++;
                end
            end
            chk($sformatf("rr%0d_words", t), nw, 6);
            step();
            chk($sformatf("rr%0d_word_ctr", t), word_ctr, 6);
            chk($sformatf("rr%0d_bad_ack", t), bad_ack, 0);
            chk($sformatf("rr%0d_ack_len", t), ack_long, 0);
        end

        // Stall timeout on source 1
        do_reset();
        src_enable = 3'b111;
        src_syn    = 3'b101;
        out_ack    = 1'b1;
        enable     = 1'b1;
        found = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (word_ctr == 32'd1) begin found = 1; break; end
        end
        chk("tmo_first_word", found, 1);
        for (int k = 1; k <= 17; k++) begin
            step();
            if (src_ack[1]) chk("tmo_no_ack1", 32'(src_ack), 0);
            if (k == 16) chk("tmo_flag_early", 32'(timeout_flags), 0);
            if (k == 17) chk("tmo_flag_set", 32'(timeout_flags), 32'b010);
        end
        next_word(ws, wd, ok); chk("tmo_skip_a", 32'(ws), 2);
        next_word(ws, wd, ok); chk("tmo_skip_b", 32'(ws), 0);
        next_word(ws, wd, ok); chk("tmo_skip_c", 32'(ws), 2);
        timeout_clear = 1'b1;
        step();
        timeout_clear = 1'b0;
        chk("tmo_cleared", 32'(timeout_flags), 0);
        src_syn = 3'b111;
        found = 0;
        for (int w = 0; w < 4 && found == 0; w++) begin
            next_word(ws, wd, ok);
            if (ok && ws == 3'd1) begin
                found = 1;
                chk("tmo_revisit_data", wd, 32'hdeaddead);
            end
        end
        chk("tmo_revisit", found, 1);
        src_syn = 3'b101;
        found = 0;
        for (int w = 0; w < 6 && found == 0; w++) begin
            next_word(ws, wd, ok);
            if (ok && ws == 3'd0) found = 1;
        end
        chk("coin_find0", found, 1);
        step();
        repeat (16) step();
        chk("coin_pre", 32'(timeout_flags), 0);
        timeout_clear = 1'b1;
        step();
        timeout_clear = 1'b0;
        chk("coin_set_wins", 32'(timeout_flags), 32'b010);

        // Backpressure
        do_reset();
        src_enable = 3'b111;
        src_syn    = 3'b111;
        out_ack    = 1'b0;
        enable     = 1'b1;
        next_word(ws, wd, ok);
        chk("bp_src", 32'(ws), 0);
        chk("bp_data", wd, 32'h01020304);
        dev = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (out_syn !== 1'b1 || out_data !== wd || out_src !== ws ||
                src_ack !== '0 || word_ctr !== 32'd0) dev++;
        end
        chk("bp_hold", dev, 0);
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        chk("bp_word_ctr", word_ctr, 1);
        chk("bp_syn_low", 32'(out_syn), 0);

        // Abort in PRESENT, then resume after the aborted source
        next_word(ws, wd, ok);
        chk("abort_src", 32'(ws), 1);
        enable = 1'b0;
        step();
        chk("abort_syn", 32'(out_syn), 0);
        chk("abort_ctr", word_ctr, 1);
        step();
        step();
        chk("abort_ctr_hold", word_ctr, 1);
        enable  = 1'b1;
        out_ack = 1'b1;
        next_word(ws, wd, ok);
        chk("resume_src", 32'(ws), 2);
        chk("resume_data", wd, 32'hbeefbeef);
        step();
        chk("resume_ctr", word_ctr, 2);

        // Asynchronous reset while waiting in WAIT_SYN
        src_syn = '0;
        repeat (4) step();
        chk("pre_rst_ctr", word_ctr, 2);
        chk("pre_rst_src", 32'(out_src), 2);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_syn", 32'(out_syn), 0);
        chk("arst_ack", 32'(src_ack), 0);
        chk("arst_data", out_data, 0);
        chk("arst_src", 32'(out_src), 0);
        chk("arst_ctr", word_ctr, 0);

        // word_ctr wrap
        do_reset();
        force dut.word_ctr = 32'hffffffff;
        step();
        release dut.word_ctr;
        step();
        chk("wrap_pre", word_ctr, 32'hffffffff);
        src_enable = 3'b111;
        src_syn    = 3'b111;
        out_ack    = 1'b1;
        enable     = 1'b1;
        next_word(ws, wd, ok);
        step();
        chk("wrap_zero", word_ctr, 0);

        // Randomized run against a transaction-level model
        do_reset();
        m_ptr = N - 1; m_mask = 3'b111; m_pending = 1'b0; m_words = 0;
        m_src = 0; m_data = 0; idle_cnt = 0; off_cnt = 0;
        for (int i = 0; i < N; i++) begin
            cur[i] = $urandom;
            cd[i]  = $urandom_range(0, 5);
        end
        src_enable = m_mask;
        src_syn    = '0;
        src_data   = {cur[2], cur[1], cur[0]};
        out_ack    = 1'b1;
        enable     = 1'b1;
        p_syn = 1'b0; p_ack = 1'b1; p_en = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            step();
            if (p_syn && p_ack && p_en) begin
                m_words++;
                m_pending = 1'b0;
            end
            if (!p_en) m_pending = 1'b0;
            if (src_ack != '0) begin
                exp_i = next_elig(m_ptr, m_mask);
                chk("rnd_ack", 32'(src_ack), (exp_i < 0) ? 32'd0 : (32'd1 << exp_i));
                if (exp_i >= 0) begin
                    m_ptr = exp_i; m_pending = 1'b1; m_src = exp_i; m_data = cur[exp_i];
                end
                for (int i = 0; i < N; i++) begin
                    if (src_ack[i]) begin
                        src_syn[i] = 1'b0;
                        cd[i] = $urandom_range(0, 5);
                    end
                end
                idle_cnt = 0;
            end else if (p_en) begin
                idle_cnt++;
            end
            if (idle_cnt > 80) begin
                chk("rnd_progress", idle_cnt, 0);
                idle_cnt = 0;
            end
            chk("rnd_syn", 32'(out_syn), 32'(m_pending));
            if (out_syn && m_pending) begin
                chk("rnd_src", 32'(out_src), m_src);
                chk("rnd_data", out_data, m_data);
            end
            chk("rnd_word_ctr", word_ctr, m_words);
            chk("rnd_flags", 32'(timeout_flags), 0);
            for (int i = 0; i < N; i++) begin
                if (!src_syn[i]) begin
                    if (cd[i] == 0) begin
                        src_syn[i] = 1'b1;
                        cur[i] = $urandom;
                    end else begin
                        cd[i]--;
                    end
                end
            end
            src_data = {cur[2], cur[1], cur[0]};
            out_ack  = ($urandom_range(0, 2) != 0);
            if (enable) begin
                if ($urandom_range(0, 39) == 0) begin
                    enable  = 1'b0;
                    off_cnt = $urandom_range(1, 3);
                end
            end else begin
                off_cnt--;
                if (off_cnt == 0) begin
                    m_mask     = 3'($urandom_range(1, 7));
                    src_enable = m_mask;
                    enable     = 1'b1;
                end
            end
            p_syn = out_syn;
            p_ack = out_ack;
            p_en  = enable;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trng_entropy_arbiter.md
# trng_entropy_arbiter

Round-robin scheduler that shares the TRNG mixer's single entropy input among several entropy sources (ring oscillator, avalanche, etc.). Each source uses a syn/data/ack word handshake. The arbiter visits enabled sources in turn, captures one 32-bit word per visit and presents it to the mixer on a syn/ack output port. A per-source watchdog skips and flags any source that stalls.

## Interface
Parameters:
- NUM_SRC, 3: number of entropy sources, legal range 2..8.
- TIMEOUT, 16'h0400: maximum number of cycles to wait for src_syn before the source is declared stalled.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  global arbiter enable.
- src_enable  in  NUM_SRC  per-source enable mask.
- src_syn  in  NUM_SRC  per-source word-valid.
- src_data  in  32*NUM_SRC  source i's word is at bits [32*i+31 : 32*i].
- src_ack  out  NUM_SRC  one-cycle acknowledge to the selected source.
- out_syn  out  1  captured word valid to the mixer.
- out_data  out  32  captured word.
- out_src  out  3  index of the source that produced out_data.
- out_ack  in  1  mixer consumed the word.
- timeout_flags  out  NUM_SRC  sticky per-source stall flags.
- timeout_clear  in  1  clears all timeout_flags.
- word_ctr  out  32  count of words delivered to the mixer.

## Operation
- Reset values: all outputs are 0, the FSM is in IDLE, and rr_ptr = NUM_SRC-1, so that source 0 is visited first.
- Eligible source: src_enable[i] = 1 and timeout_flags[i] = 0.
- FSM states: IDLE, SELECT, WAIT_SYN, PRESENT.
- IDLE: when enable = 1, go to SELECT.
- SELECT: pick the first eligible source searching from rr_ptr+1 upward, with modular wrap. Load it into sel, clear the timer, go to WAIT_SYN. If no source is eligible, stay in SELECT.
- WAIT_SYN, src_syn[sel] = 1:
  - Capture the word into out_data and sel into out_src.
  - Pulse src_ack[sel] for exactly one cycle.
  - Go to PRESENT.
- WAIT_SYN, stall: if the timer reaches TIMEOUT-1 without src_syn, set timeout_flags[sel], set rr_ptr = sel, go to SELECT. No ack is issued.
- WAIT_SYN, source disabled: if src_enable[sel] falls, set rr_ptr = sel and go to SELECT. No flag is set.
- PRESENT: out_syn = 1, with out_data and out_src held stable. When out_ack = 1:
  - word_ctr increments.
  - rr_ptr = sel.
  - Go to SELECT.
- enable = 0 in any state: go to IDLE on the next edge.
  - out_syn and src_ack are forced to 0.
  - A word captured but not yet delivered is discarded and not counted.
  - rr_ptr is retained.
- word_ctr wraps from 32'hffffffff to 0 with no flag.
- timeout_flags: sticky. timeout_clear zeroes all flags. If a new timeout and timeout_clear occur in the same cycle, the new timeout bit is set (set wins).
- A timed-out source is skipped until it is cleared.
- src_syn on non-selected sources is ignored and never acked.

## Timing
- Cycle N: WAIT_SYN samples src_syn[sel] = 1.
- Cycle N+1:
  - src_ack[sel] = 1 (registered; low again at N+2).
  - out_syn = 1.
  - out_data and out_src are valid.
- out_ack sampled high at cycle M: out_syn = 0 at M+1, word_ctr updated at M+1, SELECT at M+1.
- Best case is 3 cycles per word: SELECT, WAIT_SYN, PRESENT with out_ack already high.
- Timeout: the flag is visible exactly TIMEOUT cycles after WAIT_SYN is entered.
- reset is asynchronous. Asserting it mid-handshake drops src_ack and out_syn immediately.
- Sources hold src_data stable while src_syn is high.

## Structure
- Shared package trng_pkg holds:
  - state encoding constants CTRL_IDLE = 0, CTRL_SELECT = 1, CTRL_WAIT_SYN = 2, CTRL_PRESENT = 3;
  - default constant TRNG_SRC_TIMEOUT = 16'h0400;
  - SRC_IDX_W = 3.
- One sub-module: trng_rr_select. It is combinational: inputs are the eligible mask and rr_ptr, outputs are the selected index and a valid bit.
- The FSM, timer, capture registers, counter and flags all live in trng_entropy_arbiter.

## Test plan
- Round robin: all 3 sources enabled with src_syn held high, data 32'h01020304 / 32'hdeaddead / 32'hbeefbeef, out_ack held high. Required: out_src sequence 0,1,2,0,…; out_data matches the source; word_ctr = 6 after 6 words; each src_ack is a one-cycle pulse.
- Skip disabled source: src_enable = 3'b101. Required: out_src alternates 0,2; src_ack[1] never asserts.
- Stall timeout: TIMEOUT = 16, source 1 with src_syn = 0. Required: timeout_flags = 3'b010 exactly 16 cycles after WAIT_SYN on source 1; source 1 is then skipped. After timeout_clear, source 1 is revisited. When a timeout and timeout_clear coincide, the flag stays set.
- Backpressure: out_ack held low for 20 cycles. Required: out_syn stays 1; out_data and out_src stay stable; no further src_ack; word_ctr unchanged until out_ack.
- Abort: enable dropped while in PRESENT. Required: out_syn = 0 next cycle; word_ctr unchanged; FSM in IDLE. After re-enable, arbitration resumes with the source after the aborted one.
- Reset and wrap:
  - Assert reset mid-WAIT_SYN: all outputs 0 immediately.
  - Force word_ctr to 32'hffffffff and deliver one word: word_ctr becomes 0.
